aes_add_round_key_out: RTL and testbench
========================================

// Module: aes_add_round_key_out
// PURPOSE
//  Pipeline stage directly downstream of the MixColumns/XOR stage of the AES-128 round pipeline.
//  - Applies AddRoundKey (state ^ round key) and forwards state, key and Rcon to the next round stage.
//  - A final-round block (Rcon == FINAL_RCON) is routed instead into a show-ahead ciphertext FIFO.
//  - The FIFO drains to the host interface through a valid/ready handshake.
// PARAMETERS
//  FIFO_DEPTH  4      ciphertext FIFO entries; power of 2, >= 2
//  FINAL_RCON  8'h36  Rcon value that tags the final (10th) round
// PORTS
//  clock       in   1    rising-edge clock, single clock domain
//  reset       in   1    synchronous, active-high reset
//  state_in    in   128  round state from MixColumns stage; byte 0 = [127:120] ... byte F = [7:0]
//  key_in      in   128  round key from MixColumns stage, same byte order
//  rcon_in     in   8    Rcon tag travelling with the block
//  empty_in    in   1    1 = input slot carries no data (bubble)
//  state_out   out  128  state ^ key for next round stage
//  key_out     out  128  key forwarded unchanged for next-round expansion
//  rcon_out    out  8    Rcon forwarded
//  empty_out   out  1    1 = round output slot is a bubble
//  ct_data     out  128  ciphertext at FIFO head (show-ahead)
//  ct_valid    out  1    FIFO non-empty
//  ct_ready    in   1    host accepts ct_data when ct_valid & ct_ready
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently held
//  overflow    out  1    sticky: a final-round block was dropped on a full FIFO
// BEHAVIOUR
//  Reset:
//  - All outputs reset to 0, except empty_out, which resets to 1.
//  - FIFO pointers and count are cleared; overflow is cleared.
//  - In-flight data is discarded, including when reset is asserted mid-operation.
//  Stage register (1 cycle):
//  - sum = state_in ^ key_in, bytewise (pure 128-bit XOR); no arithmetic carry.
//  - fin = !empty_in && (rcon_in == FINAL_RCON).
//  Round path, latency 1:
//  - key_out and rcon_out are registered from key_in and rcon_in every cycle.
//  - If !empty_in && !fin: state_out <= sum, empty_out <= 0.
//  - Otherwise: state_out <= 0, empty_out <= 1. A final block never reaches the round path.
//  Ciphertext path:
//  - fin and sum are registered (wr_en, wr_data) on the same edge.
//  - The FIFO write occurs on the following edge, so ct_valid rises 2 cycles after the final block is presented.
//  - Bubbles (empty_in = 1) never write the FIFO, whatever their Rcon value.
//  - Read: on ct_valid & ct_ready the head pops; ct_data shows the next entry on the next cycle.
//  - ct_data is 0 while the FIFO is empty.
//  - ct_data is stable while ct_valid & !ct_ready.
//  - Pointers wrap modulo FIFO_DEPTH.
//  - Full, write only: the write is dropped, overflow <= 1, and the FIFO contents are unchanged.
//  - Full, write and read in the same cycle: both happen; count is unchanged and no overflow is flagged.
//  - Empty, write and read in the same cycle: the read is ignored (ct_valid = 0); the write lands.
//  - Count: +1 on a write alone, -1 on a read alone, unchanged on both or neither.
//  - overflow is cleared only by reset.
//  No back-pressure to the round pipeline: the round path advances every cycle.
// TESTING
//  T1 Reset:
//     - Stimulus: assert reset for 2 cycles with random inputs.
//     - Required: empty_out = 1, ct_valid = 0, fifo_count = 0, overflow = 0, all data outputs 0.
//  T2 Mid round:
//     - Stimulus: state = {16{8'hAA}}, key = {16{8'h55}}, rcon = 8'h01, empty_in = 0.
//     - Required, next cycle: state_out = {16{8'hFF}}, key_out = {16{8'h55}}, rcon_out = 8'h01, empty_out = 0, FIFO untouched.
//  T3 Final round:
//     - Stimulus: state = 128'h000102...0F, key = {16{8'h0F}}, rcon = 8'h36.
//     - Required: empty_out = 1 after 1 cycle.
//     - Required: ct_valid = 1 after 2 cycles with ct_data = 128'h0F0E0D0C0B0A09080706050403020100.
//     - Required: ct_ready = 1 pops it; ct_valid = 0 on the next cycle.
//  T4 Bubble tagged 8'h36:
//     - Stimulus: empty_in = 1, rcon = 8'h36.
//     - Required: no FIFO write, empty_out = 1, fifo_count stays 0.
//  T5 Overflow:
//     - Stimulus: ct_ready = 0; send 5 final blocks with data 1..5.
//     - Required: fifo_count = 4 and overflow = 1.
//     - Required: on drain, ct_data = 1, 2, 3, 4 in order; block 5 is absent.
//  T6 Full, simultaneous read/write:
//     - Stimulus: FIFO full; ct_ready = 1 in the same cycle a final block writes.
//     - Required: fifo_count stays 4, overflow stays 0, the new block is delivered last.
//     - Repeat across pointer wrap-around.

Source files
------------

// File: rtl/aes_add_round_key_out.sv
// -----------------------------------------------------------------------------
// aes_add_round_key_out
//
// AddRoundKey stage that sits directly after the MixColumns/XOR stage of the
// AES-128 round pipeline.
//
// Each cycle, the stage XORs the incoming state with its round key.
// - Ordinary rounds are registered onto the round path, together with the key
//   and the Rcon tag, for the next round stage.
// - A final-round block (rcon_in == FINAL_RCON) is diverted into a show-ahead
//   ciphertext FIFO. The host drains that FIFO with a valid/ready handshake.
// - The round pipeline is never back-pressured. If a final block arrives while
//   the FIFO is full and nothing is being read, the block is dropped and the
//   sticky overflow flag is set.
//
// Parameters
//   FIFO_DEPTH  ciphertext FIFO entries (power of 2, >= 2)
//   FINAL_RCON  Rcon value tagging the final (10th) round
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   state_in    round state; byte 0 = [127:120] ... byte F = [7:0]
//   key_in      round key, same byte order
//   rcon_in     Rcon tag travelling with the block
//   empty_in    1 = input slot is a bubble
//   state_out   state ^ key for the next round stage (0 for bubbles/final)
//   key_out     key forwarded unchanged
//   rcon_out    Rcon forwarded
//   empty_out   1 = round output slot is a bubble
//   ct_data     ciphertext at FIFO head, 0 while empty
//   ct_valid    FIFO non-empty
//   ct_ready    host accepts ct_data when ct_valid & ct_ready
//   fifo_count  entries currently held
//   overflow    sticky: a final block was dropped on a full FIFO
// -----------------------------------------------------------------------------
module aes_add_round_key_out #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] FINAL_RCON = 8'h36
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [127:0]                  state_in,
  input  logic [127:0]                  key_in,
  input  logic [7:0]                    rcon_in,
  input  logic                          empty_in,
  output logic [127:0]                  state_out,
  output logic [127:0]                  key_out,
  output logic [7:0]                    rcon_out,
  output logic                          empty_out,
  output logic [127:0]                  ct_data,
  output logic                          ct_valid,
  input  logic                          ct_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Stage register
  // ---------------------------------------------------------------------------
  logic [127:0] sum;
  logic         fin;

  // AddRoundKey is a plain bitwise XOR; there is no carry between bytes.
  assign sum = state_in ^ key_in;
  assign fin = !empty_in && (rcon_in == FINAL_RCON);

  logic         wr_en;
  logic [127:0] wr_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_out <= '0;
      key_out   <= '0;
      rcon_out  <= '0;
      empty_out <= 1'b1;
      wr_en     <= 1'b0;
      wr_data   <= '0;
    end else begin
      key_out  <= key_in;
      rcon_out <= rcon_in;
      wr_en    <= fin;
      wr_data  <= sum;
      // Final blocks leave the round path as bubbles; their data goes to
      // the FIFO only.
      if (!empty_in && !fin) begin
        state_out <= sum;
        empty_out <= 1'b0;
      end else begin
        state_out <= '0;
        empty_out <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Ciphertext FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [127:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          full;
  logic          rd_fire;
  logic          wr_fire;

  assign full     = (count_q == FULL_COUNT);
  assign ct_valid = (count_q != '0);
  // A read is only possible on an occupied FIFO. A pop frees the head slot in
  // the same cycle, so a write to a full FIFO can still land when it pops.
  assign rd_fire  = ct_valid && ct_ready;
  assign wr_fire  = wr_en && (!full || rd_fire);

  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      // Pointer width equals log2(depth), so the +1 wraps modulo FIFO_DEPTH.
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && full && !rd_fire) begin
        overflow <= 1'b1;
      end
      case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign fifo_count = count_q;
  assign ct_data    = ct_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_aes_add_round_key_out.sv
module tb_aes_add_round_key_out;

  localparam int DEPTH = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] state_in;
  logic [127:0] key_in;
  logic [7:0]   rcon_in;
  logic         empty_in;
  logic [127:0] state_out;
  logic [127:0] key_out;
  logic [7:0]   rcon_out;
  logic         empty_out;
  logic [127:0] ct_data;
  logic         ct_valid;
  logic         ct_ready;
  logic [2:0]   fifo_count;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  aes_add_round_key_out #(.FIFO_DEPTH(DEPTH), .FINAL_RCON(8'h36)) dut (
    .clock      (clock),
    .reset      (reset),
    .state_in   (state_in),
    .key_in     (key_in),
    .rcon_in    (rcon_in),
    .empty_in   (empty_in),
    .state_out  (state_out),
    .key_out    (key_out),
    .rcon_out   (rcon_out),
    .empty_out  (empty_out),
    .ct_data    (ct_data),
    .ct_valid   (ct_valid),
    .ct_ready   (ct_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the ciphertext FIFO is a queue, and the round path is
  // simply what the previous cycle's inputs imply.
  logic [127:0] m_state;
  logic [127:0] m_key;
  logic [7:0]   m_rcon;
  logic         m_empty;
  logic         m_ovf;
  logic         m_pend;
  logic [127:0] m_pend_data;
  logic [127:0] m_q[$];
  bit           model_live = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_state = '0; m_key = '0; m_rcon = '0; m_empty = 1'b1;
      m_ovf = 1'b0; m_pend = 1'b0; m_pend_data = '0;
      m_q.delete();
    end else begin
      logic pop;
      logic fin;
      pop = (m_q.size() > 0) && ct_ready;
      if (pop) void'(m_q.pop_front());
      if (m_pend) begin
        if (m_q.size() >= DEPTH) m_ovf = 1'b1;
        else m_q.push_back(m_pend_data);
      end
      fin = !empty_in && (rcon_in == 8'h36);
      m_pend = fin;
      m_pend_data = state_in ^ key_in;
      m_key = key_in;
      m_rcon = rcon_in;
      if (!empty_in && !fin) begin
        m_state = state_in ^ key_in;
        m_empty = 1'b0;
      end else begin
        m_state = '0;
        m_empty = 1'b1;
      end
    end
    model_live = 1;
  end

  always @(negedge clock) begin
    if (model_live) begin
      chk("m_state_out", state_out, m_state);
      chk("m_key_out", key_out, m_key);
      chk("m_rcon_out", 128'(rcon_out), 128'(m_rcon));
      chk("m_empty_out", 128'(empty_out), 128'(m_empty));
      chk("m_ct_valid", 128'(ct_valid), 128'(m_q.size() > 0));
      chk("m_ct_data", ct_data, (m_q.size() > 0) ? m_q[0] : 128'h0);
      chk("m_fifo_count", 128'(fifo_count), 128'(m_q.size()));
      chk("m_overflow", 128'(overflow), 128'(m_ovf));
    end
  end

  // Present one input slot; return after the edge that consumed it, at the
  // following falling edge.
  task automatic apply(input logic rst, input logic [127:0] st, input logic [127:0] ky,
                       input logic [7:0] rc, input logic emp, input logic rdy);
    reset = rst; state_in = st; key_in = ky; rcon_in = rc; empty_in = emp; ct_ready = rdy;
    @(negedge clock);
  endtask

  task automatic bubble(input logic rdy);
    apply(1'b0, '0, '0, 8'h00, 1'b1, rdy);
  endtask

  initial begin
    logic [127:0] rnd;
    logic [127:0] v;
    reset = 1'b1; state_in = '0; key_in = '0; rcon_in = '0; empty_in = 1'b1; ct_ready = 1'b0;

    // T1 reset with random inputs
    for (int i = 0; i < 2; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      apply(1'b1, rnd, ~rnd, 8'($urandom), 1'($urandom), 1'($urandom));
    end
    chk("t1_empty_out", 128'(empty_out), 128'h1);
    chk("t1_ct_valid", 128'(ct_valid), 128'h0);
    chk("t1_fifo_count", 128'(fifo_count), 128'h0);
    chk("t1_overflow", 128'(overflow), 128'h0);
    chk("t1_state_out", state_out, 128'h0);
    chk("t1_ct_data", ct_data, 128'h0);

    // T2 mid round
    apply(1'b0, {16{8'hAA}}, {16{8'h55}}, 8'h01, 1'b0, 1'b0);
    chk("t2_state_out", state_out, {16{8'hFF}});
    chk("t2_key_out", key_out, {16{8'h55}});
    chk("t2_rcon_out", 128'(rcon_out), 128'h01);
    chk("t2_empty_out", 128'(empty_out), 128'h0);
    bubble(1'b0);
    chk("t2_fifo_count", 128'(fifo_count), 128'h0);

    // T3 final round
    apply(1'b0, 128'h000102030405060708090A0B0C0D0E0F, {16{8'h0F}}, 8'h36, 1'b0, 1'b0);
    chk("t3_empty_out", 128'(empty_out), 128'h1);
    chk("t3_ct_valid_early", 128'(ct_valid), 128'h0);
    bubble(1'b0);
    chk("t3_ct_valid", 128'(ct_valid), 128'h1);
    chk("t3_ct_data", ct_data, 128'h0F0E0D0C0B0A09080706050403020100);
    bubble(1'b1);
    chk("t3_ct_valid_popped", 128'(ct_valid), 128'h0);
    chk("t3_ct_data_empty", ct_data, 128'h0);

    // T4 bubble tagged with the final Rcon
    apply(1'b0, {16{8'h12}}, {16{8'h34}}, 8'h36, 1'b1, 1'b0);
    chk("t4_empty_out", 128'(empty_out), 128'h1);
    bubble(1'b0);
    chk("t4_fifo_count", 128'(fifo_count), 128'h0);
    chk("t4_ct_valid", 128'(ct_valid), 128'h0);

    // T5 overflow: five final blocks, no reads
    for (int i = 1; i <= 5; i++) begin
      v = 128'(i);
      apply(1'b0, v, '0, 8'h36, 1'b0, 1'b0);
    end
    bubble(1'b0);
    bubble(1'b0);
    chk("t5_fifo_count", 128'(fifo_count), 128'h4);
    chk("t5_overflow", 128'(overflow), 128'h1);
    for (int i = 1; i <= 4; i++) begin
      chk("t5_drain_data", ct_data, 128'(i));
      bubble(1'b1);
    end
    chk("t5_drained", 128'(ct_valid), 128'h0);
    chk("t5_overflow_sticky", 128'(overflow), 128'h1);

    apply(1'b1, '0, '0, 8'h00, 1'b1, 1'b0);
    apply(1'b1, '0, '0, 8'h00, 1'b1, 1'b0);
    chk("t5_overflow_reset", 128'(overflow), 128'h0);

    // T6 full FIFO with simultaneous read and write, twice to cross the wrap
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 4; i++) begin
        v = 128'(16 * (rep + 1) + i);
        apply(1'b0, v, {16{8'hC3}}, 8'h36, 1'b0, 1'b0);
      end
      v = 128'(16 * (rep + 1) + 4);
      apply(1'b0, v, {16{8'hC3}}, 8'h36, 1'b0, 1'b0);
      chk("t6_full_count", 128'(fifo_count), 128'h4);
      bubble(1'b1);
      ct_ready = 1'b0;
      chk("t6_count_kept", 128'(fifo_count), 128'h4);
      chk("t6_no_overflow", 128'(overflow), 128'h0);
      for (int i = 1; i <= 4; i++) begin
        v = 128'(16 * (rep + 1) + i) ^ {16{8'hC3}};
        chk("t6_drain_data", ct_data, v);
        bubble(1'b1);
      end
      chk("t6_drained", 128'(fifo_count), 128'h0);
    end

    bubble(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
